// File: rtl/digit_classifier.sv
// digit_classifier: sequential arg-max decoder for the output layer.
// Captures a per-digit confidence vector and a one-hot expected label, scans
// the confidences one per cycle, and reports the winning digit as an index,
// a one-hot label and its confidence, plus match / label-error flags.
//
// Ports:
//   clk                     - system clock, rising edge
//   rst                     - asynchronous active-high reset
//   classify_en             - start request, honoured only while idle
//   digit_weights           - per-digit confidences, captured at start
//   expected_label          - one-hot expected digit, captured at start
//   classification_complete - high while idle; results valid
//   predicted_digit         - index of the winning digit
//   predicted_label         - one-hot form of predicted_digit
//   max_confidence          - confidence of the winning digit
//   match                   - prediction equals the captured expected label
//   label_error             - captured expected label was not exactly one-hot
module digit_classifier #(
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned CONF_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  classify_en,
  input  logic [0:NUM_DIGITS-1][CONF_WIDTH-1:0] digit_weights,
  input  logic [0:NUM_DIGITS-1]                 expected_label,
  output logic                                  classification_complete,
  output logic [3:0]                            predicted_digit,
  output logic [0:NUM_DIGITS-1]                 predicted_label,
  output logic [CONF_WIDTH-1:0]                 max_confidence,
  output logic                                  match,
  output logic                                  label_error
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [0:NUM_DIGITS-1][CONF_WIDTH-1:0] hold_q, hold_d;
  logic [0:NUM_DIGITS-1]                 label_q, label_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [IDX_W-1:0]                      best_idx_q, best_idx_d;
  logic [CONF_WIDTH-1:0]                 best_val_q, best_val_d;
  logic                                  complete_q, complete_d;
  logic [3:0]                            pred_digit_q, pred_digit_d;
  logic [0:NUM_DIGITS-1]                 pred_label_q, pred_label_d;
  logic [CONF_WIDTH-1:0]                 max_conf_q, max_conf_d;
  logic                                  match_q, match_d;
  logic                                  label_err_q, label_err_d;

  // One-hot decode of a digit index, bit 0 of the label is digit 0.
  function automatic logic [0:NUM_DIGITS-1] one_hot(input logic [IDX_W-1:0] idx);
    logic [0:NUM_DIGITS-1] oh;
    oh = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      oh[i] = (IDX_W'(i) == idx);
    end
    return oh;
  endfunction

  // Number of set bits in a label.
  function automatic int unsigned pop_count(input logic [0:NUM_DIGITS-1] lbl);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      cnt = cnt + 32'(lbl[i]);
    end
    return cnt;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      label_q      <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      complete_q   <= 1'b1;
      pred_digit_q <= '0;
      pred_label_q <= '0;
      max_conf_q   <= '0;
      match_q      <= 1'b0;
      label_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      label_q      <= label_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      complete_q   <= complete_d;
      pred_digit_q <= pred_digit_d;
      pred_label_q <= pred_label_d;
      max_conf_q   <= max_conf_d;
      match_q      <= match_d;
      label_err_q  <= label_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic label_bad;
    state_d      = state_q;
    hold_d       = hold_q;
    label_d      = label_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    pred_digit_d = pred_digit_q;
    pred_label_d = pred_label_q;
    max_conf_d   = max_conf_q;
    match_d      = match_q;
    label_err_d  = label_err_q;
    label_bad    = (pop_count(label_q) != 1);

    unique case (state_q)
      IDLE: begin
        if (classify_en) begin
          hold_d     = digit_weights;
          label_d    = expected_label;
          best_val_d = digit_weights[0];
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (hold_q[idx_q] > best_val_q) begin
          best_val_d = hold_q[idx_q];
          best_idx_d = idx_q;
        end
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FIN: begin
        pred_digit_d = 4'(best_idx_q);
        pred_label_d = one_hot(best_idx_q);
        max_conf_d   = best_val_q;
        match_d      = !label_bad && (one_hot(best_idx_q) == label_q);
        label_err_d  = label_bad;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    complete_d = (state_d == IDLE);
  end

  assign classification_complete = complete_q;
  assign predicted_digit         = pred_digit_q;
  assign predicted_label         = pred_label_q;
  assign max_confidence          = max_conf_q;
  assign match                   = match_q;
  assign label_error             = label_err_q;

endmodule

// File: tb/tb_digit_classifier.sv
// Self-checking bench for digit_classifier: table of directed vectors plus
// hand-written sequences for reset, input hold, back-to-back and mid-run reset.
module tb_digit_classifier;

  logic             clk;
  logic             rst;
  logic             classify_en;
  logic [0:9][3:0]  digit_weights;
  logic [0:9]       expected_label;
  logic             classification_complete;
  logic [3:0]       predicted_digit;
  logic [0:9]       predicted_label;
  logic [3:0]       max_confidence;
  logic             match;
  logic             label_error;

  int n_checks;
  int n_fail;

  digit_classifier #(.NUM_DIGITS(10), .CONF_WIDTH(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .classify_en             (classify_en),
    .digit_weights           (digit_weights),
    .expected_label          (expected_label),
    .classification_complete (classification_complete),
    .predicted_digit         (predicted_digit),
    .predicted_label         (predicted_label),
    .max_confidence          (max_confidence),
    .match                   (match),
    .label_error             (label_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] w;
    logic [9:0]  lbl;
    logic [3:0]  dig;
    logic [9:0]  plbl;
    logic [3:0]  conf;
    logic        m;
    logic        e;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles with classification_complete low after the start edge.
  task automatic wait_done(output int cycles);
    cycles = 1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (classification_complete) return;
      cycles++;
    end
    cycles = -1;
  endtask

  task automatic start_run(input logic [39:0] w, input logic [9:0] lbl);
    @(negedge clk);
    digit_weights  = w;
    expected_label = lbl;
    classify_en    = 1'b1;
    @(posedge clk); #1;
    classify_en    = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] dig, input logic [9:0] plbl,
                              input logic [3:0] conf, input logic m, input logic e);
    check({tag, ".digit"}, 32'(predicted_digit), 32'(dig));
    check({tag, ".label"}, 32'(predicted_label), 32'(plbl));
    check({tag, ".conf"},  32'(max_confidence),  32'(conf));
    check({tag, ".match"}, 32'(match),           32'(m));
    check({tag, ".lerr"},  32'(label_error),     32'(e));
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"single",  40'h1234567F32, 10'b0000000100, 4'd7, 10'b0000000100, 4'hF, 1'b1, 1'b0};
    vecs[1] = '{"tie",     40'h0909000009, 10'b0001000000, 4'd1, 10'b0100000000, 4'h9, 1'b0, 1'b0};
    vecs[2] = '{"zerolbl", 40'h0000000000, 10'b0000000000, 4'd0, 10'b1000000000, 4'h0, 1'b0, 1'b1};
    vecs[3] = '{"twohot",  40'h0000000000, 10'b1100000000, 4'd0, 10'b1000000000, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{"last",    40'h123456789A, 10'b0000000001, 4'd9, 10'b0000000001, 4'hA, 1'b1, 1'b0};
    vecs[5] = '{"ends",    40'hF00000000F, 10'b1000000000, 4'd0, 10'b1000000000, 4'hF, 1'b1, 1'b0};
    vecs[6] = '{"mixed",   40'h5A3A0BB21B, 10'b0000010000, 4'd5, 10'b0000010000, 4'hB, 1'b1, 1'b0};

    // Reset with a start request pending.
    rst            = 1'b1;
    classify_en    = 1'b1;
    digit_weights  = 40'h1234567F32;
    expected_label = 10'b0000000100;
    repeat (3) @(posedge clk);
    #1;
    check("rst.complete", 32'(classification_complete), 32'd1);
    check_result("rst", 4'd0, 10'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    classify_en = 1'b0;
    rst         = 1'b0;
    @(posedge clk); #1;
    check("idle.complete", 32'(classification_complete), 32'd1);

    // Table-driven runs.
    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].w, vecs[i].lbl);
      check({vecs[i].name, ".busy"}, 32'(classification_complete), 32'd0);
      wait_done(cyc);
      check({vecs[i].name, ".latency"}, 32'(cyc), 32'd10);
      check_result(vecs[i].name, vecs[i].dig, vecs[i].plbl, vecs[i].conf, vecs[i].m, vecs[i].e);
    end

    // Inputs changed and a second start requested mid-run are ignored.
    start_run(40'h000000000F, 10'b0000000001);
    @(posedge clk); #1;
    @(negedge clk);
    digit_weights  = 40'h0;
    expected_label = 10'b0;
    classify_en    = 1'b1;
    @(negedge clk);
    classify_en    = 1'b0;
    cyc = 3;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (classification_complete) break;
      cyc++;
    end
    check("hold.latency", 32'(cyc), 32'd10);
    check_result("hold", 4'd9, 10'b0000000001, 4'hF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold.single_run", 32'(classification_complete), 32'd1);

    // Back-to-back runs with classify_en held high.
    @(negedge clk);
    digit_weights  = 40'h0000300000;
    expected_label = 10'b0000100000;
    classify_en    = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc);
    check("b2b.latency", 32'(cyc), 32'd10);
    check_result("b2b", 4'd4, 10'b0000100000, 4'h3, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("b2b.restart", 32'(classification_complete), 32'd0);
    classify_en = 1'b0;
    wait_done(cyc);
    check("b2b.latency2", 32'(cyc), 32'd10);

    // Asynchronous reset in the middle of a scan.
    start_run(40'h00000000F0, 10'b0000000010);
    repeat (4) @(posedge clk);
    #1;
    check("mid.busy", 32'(classification_complete), 32'd0);
    rst = 1'b1;
    #1;
    check("mid.complete", 32'(classification_complete), 32'd1);
    check_result("mid", 4'd0, 10'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start_run(40'hF000000000, 10'b1000000000);
    wait_done(cyc);
    check("post.latency", 32'(cyc), 32'd10);
    check_result("post", 4'd0, 10'b1000000000, 4'hF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
